// File: rtl/exception_unit_pkg.sv
// exc_pkg: shared CSR addresses, trap causes, state encoding and
// the CSR read-modify-write helper for the exception unit.
package exc_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;
  localparam logic [31:0] CAUSE_MEXT_INT = 32'h8000_000B;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CSR_NOP   = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic        take;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } trap_t;

  function automatic logic [31:0] csr_apply(
    csr_op_e     op,
    logic [31:0] old,
    logic [31:0] v
  );
    logic [31:0] r;
    case (op)
      CSR_WRITE: r = v;
      CSR_SET:   r = old | v;
      CSR_CLEAR: r = old & ~v;
      default:   r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exception_unit_if.sv
// exception_unit_if: WB-stage exception/CSR bundle between the
// pipeline (master) and the exception unit (slave).
interface exception_unit_if;
  logic        inst_valid;
  logic [1:0]  exp_vector;
  logic        mret;
  logic        interrupt;
  logic        csr_rw;
  logic        csr_w_imm_mux;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic [31:0] epc_cur;
  logic [31:0] epc_next;
  logic [31:0] inst_word;
  logic [31:0] csr_rdata;
  logic        redirect_mux;
  logic [31:0] redirect_pc;
  logic        reg_FD_flush;
  logic        reg_DE_flush;
  logic        reg_EM_flush;
  logic        reg_MW_flush;
  logic        RegWrite_cancel;

  modport master (
    output inst_valid, exp_vector, mret, interrupt,
    output csr_rw, csr_w_imm_mux, csr_funct3, csr_addr,
    output rs1_data, zimm, epc_cur, epc_next, inst_word,
    input  csr_rdata, redirect_mux, redirect_pc,
    input  reg_FD_flush, reg_DE_flush, reg_EM_flush,
    input  reg_MW_flush, RegWrite_cancel
  );

  modport slave (
    input  inst_valid, exp_vector, mret, interrupt,
    input  csr_rw, csr_w_imm_mux, csr_funct3, csr_addr,
    input  rs1_data, zimm, epc_cur, epc_next, inst_word,
    output csr_rdata, redirect_mux, redirect_pc,
    output reg_FD_flush, reg_DE_flush, reg_EM_flush,
    output reg_MW_flush, RegWrite_cancel
  );
endinterface

// File: rtl/exception_unit_csr_regfile.sv
// csr_regfile: machine-mode CSR storage, read mux and RMW writes.
// Optional 64-bit mcycle counter when MCYCLE_EN is defined.
module csr_regfile
  import exc_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr_i,
  input  csr_op_e     op_i,
  input  logic [31:0] wval_i,
  input  logic        csr_en_i,
  input  trap_t       trap_i,
  input  logic        mret_i,
  input  logic        irq_i,
  output logic [31:0] rdata_o,
  output logic        mie_o,
  output logic        meie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mie_q;
  logic        mpie_q;
  logic        meie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mstatus_rd;
  logic [31:0] mie_rd;
  logic [31:0] mip_rd;
  logic [31:0] wdata;
  logic        wr_en;
`ifdef MCYCLE_EN
  logic [63:0] mcycle_q;
`endif

  // Architectural views of the sparse status/enable/pending CSRs
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mie_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
    mie_rd = '0;
    mie_rd[MIE_MEIE] = meie_q;
    mip_rd = '0;
    mip_rd[MIE_MEIE] = irq_i;
  end

  // Combinational read of the addressed CSR (old value)
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CSR_MSTATUS: rdata_o = mstatus_rd;
      CSR_MIE:     rdata_o = mie_rd;
      CSR_MTVEC:   rdata_o = mtvec_q;
      CSR_MEPC:    rdata_o = mepc_q;
      CSR_MCAUSE:  rdata_o = mcause_q;
      CSR_MTVAL:   rdata_o = mtval_q;
      CSR_MIP:     rdata_o = mip_rd;
`ifdef MCYCLE_EN
      CSR_MCYCLE:  rdata_o = mcycle_q[31:0];
      CSR_MCYCLEH: rdata_o = mcycle_q[63:32];
`endif
      default:     rdata_o = '0;
    endcase
  end

  assign wr_en = csr_en_i &&
    ((op_i == CSR_WRITE) ||
     ((op_i == CSR_SET || op_i == CSR_CLEAR) && wval_i != '0));
  assign wdata = csr_apply(op_i, rdata_o, wval_i);

  // Trap entry, MRET and CSR-instruction updates, in that priority
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtvec_q  <= {MTVEC_RST[31:2], 2'b00};
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_i.take) begin
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
      mepc_q   <= trap_i.epc;
      mcause_q <= trap_i.cause;
      mtval_q  <= trap_i.tval;
    end else if (mret_i) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_en) begin
      case (addr_i)
        CSR_MSTATUS: begin
          mie_q  <= wdata[MSTATUS_MIE];
          mpie_q <= wdata[MSTATUS_MPIE];
        end
        CSR_MIE:    meie_q   <= wdata[MIE_MEIE];
        CSR_MTVEC:  mtvec_q  <= {wdata[31:2], 2'b00};
        CSR_MEPC:   mepc_q   <= wdata;
        CSR_MCAUSE: mcause_q <= wdata;
        CSR_MTVAL:  mtval_q  <= wdata;
        default: ;
      endcase
    end
  end

`ifdef MCYCLE_EN
  // Free-running cycle counter; a CSR write to a half wins that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q <= '0;
    end else if (wr_en && addr_i == CSR_MCYCLE) begin
      mcycle_q <= {mcycle_q[63:32], wdata};
    end else if (wr_en && addr_i == CSR_MCYCLEH) begin
      mcycle_q <= {wdata, mcycle_q[31:0]};
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end
`endif

  assign mie_o   = mie_q;
  assign meie_o  = meie_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/exception_unit.sv
// exception_unit: MEM/WB trap/MRET/CSR handling, flush and redirect.
// Optional mcycle CSR pair enabled by defining MCYCLE_EN.
module exception_unit
  import exc_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter int          XLEN      = 32
) (
  input  logic             clk,
  input  logic             rst,
  exception_unit_if.slave  bus
);

  state_e            state_q;
  logic [XLEN-1:0]   tgt_q;
  logic              idle_v;
  logic              ill;
  logic              ecall;
  logic              irq;
  logic              trap_go;
  logic              mret_go;
  logic              csr_go;
  logic              ev;
  logic              redir;
  logic              mie_b;
  logic              meie_b;
  logic [XLEN-1:0]   mtvec;
  logic [XLEN-1:0]   mepc;
  logic [XLEN-1:0]   op_val;
  csr_op_e           op_kind;
  trap_t             trap;
  logic              unused_ok;

  assign idle_v  = (state_q == IDLE) && bus.inst_valid;
  assign ill     = idle_v && bus.exp_vector[1];
  assign ecall   = idle_v && !bus.exp_vector[1] &&
                   bus.exp_vector[0];
  assign irq     = idle_v && (bus.exp_vector == 2'b00) &&
                   bus.interrupt && mie_b && meie_b;
  assign trap_go = ill || ecall || irq;
  assign mret_go = idle_v && !trap_go && bus.mret;
  assign csr_go  = idle_v && !trap_go && !bus.mret &&
                   bus.csr_rw;

  // Cause, return address and trap value for the winning trap
  always_comb begin
    trap.take  = trap_go;
    trap.cause = '0;
    trap.epc   = bus.epc_cur;
    trap.tval  = '0;
    unique case (1'b1)
      ill: begin
        trap.cause = CAUSE_ILLEGAL;
        trap.tval  = bus.inst_word;
      end
      ecall: trap.cause = CAUSE_ECALL_M;
      irq: begin
        trap.cause = CAUSE_MEXT_INT;
        trap.epc   = bus.epc_next;
      end
      default: ;
    endcase
  end

  assign op_kind   = csr_op_e'(bus.csr_funct3[1:0]);
  assign op_val    = bus.csr_w_imm_mux ?
                     {27'b0, bus.zimm} : bus.rs1_data;
  assign unused_ok = bus.csr_funct3[2];

  csr_regfile #(
    .MTVEC_RST (MTVEC_RST)
  ) u_csr (
    .clk      (clk),
    .rst      (rst),
    .addr_i   (bus.csr_addr),
    .op_i     (op_kind),
    .wval_i   (op_val),
    .csr_en_i (csr_go),
    .trap_i   (trap),
    .mret_i   (mret_go),
    .irq_i    (bus.interrupt),
    .rdata_o  (bus.csr_rdata),
    .mie_o    (mie_b),
    .meie_o   (meie_b),
    .mtvec_o  (mtvec),
    .mepc_o   (mepc)
  );

  // Two-state redirect FSM; target latched on trap or MRET
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trap_go) begin
            state_q <= REDIR;
            tgt_q   <= mtvec;
          end else if (mret_go) begin
            state_q <= REDIR;
            tgt_q   <= mepc;
          end
        end
        REDIR:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ev    = trap_go || mret_go;
  assign redir = (state_q == REDIR);

  assign bus.redirect_mux    = redir;
  assign bus.redirect_pc     = redir ? tgt_q : '0;
  assign bus.reg_FD_flush    = ev || redir;
  assign bus.reg_DE_flush    = ev || redir;
  assign bus.reg_EM_flush    = ev || redir;
  assign bus.reg_MW_flush    = ev;
  assign bus.RegWrite_cancel = ill || ecall;

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: directed vectors with a scoreboard queue
// checked by an independent negedge monitor.
module tb_exception_unit;

  localparam logic [31:0] RST_VEC = 32'h0000_0200;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    bit          chk_ctl;
    logic [5:0]  ctl;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  exception_unit_if bus();

  exception_unit #(
    .MTVEC_RST (RST_VEC),
    .XLEN      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per driven cycle
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] got;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      got = {bus.redirect_mux, bus.reg_FD_flush,
             bus.reg_DE_flush, bus.reg_EM_flush,
             bus.reg_MW_flush, bus.RegWrite_cancel};
      if (e.chk_rd) begin
        n_total++;
        if (bus.csr_rdata !== e.rd)
          $display("FAIL %s rdata got %h exp %h",
                   e.name, bus.csr_rdata, e.rd);
        else n_pass++;
      end
      if (e.chk_ctl) begin
        n_total++;
        if (got !== e.ctl || bus.redirect_pc !== e.pc)
          $display("FAIL %s ctl/pc got %b/%h exp %b/%h",
                   e.name, got, bus.redirect_pc, e.ctl, e.pc);
        else n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string n, bit cr, logic [31:0] rd,
                      bit cc, logic [5:0] ctl,
                      logic [31:0] pc);
    exp_t e;
    e.name = n; e.chk_rd = cr; e.rd = rd;
    e.chk_ctl = cc; e.ctl = ctl; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic clr();
    bus.inst_valid    = 1'b0;
    bus.exp_vector    = 2'b00;
    bus.mret          = 1'b0;
    bus.interrupt     = 1'b0;
    bus.csr_rw        = 1'b0;
    bus.csr_w_imm_mux = 1'b0;
    bus.csr_funct3    = 3'b000;
    bus.csr_addr      = 12'h000;
    bus.rs1_data      = '0;
    bus.zimm          = '0;
    bus.epc_cur       = '0;
    bus.epc_next      = '0;
    bus.inst_word     = '0;
  endtask

  task automatic rd(logic [11:0] a, logic [31:0] v, string n);
    clr();
    bus.csr_addr = a;
    push(n, 1, v, 1, 6'b000000, 32'h0);
    cyc();
  endtask

  task automatic csr(logic [2:0] f3, logic [11:0] a, bit imm,
                     logic [31:0] val, logic [31:0] old,
                     string n);
    clr();
    bus.inst_valid    = 1'b1;
    bus.csr_rw        = 1'b1;
    bus.csr_funct3    = f3;
    bus.csr_addr      = a;
    bus.csr_w_imm_mux = imm;
    if (imm) bus.zimm = val[4:0];
    else bus.rs1_data = val;
    push(n, 1, old, 1, 6'b000000, 32'h0);
    cyc();
  endtask

  task automatic ev(string n, logic [5:0] ctl,
                    logic [31:0] pc);
    push(n, 0, 32'h0, 1, ctl, pc);
    cyc();
  endtask

  // REDIR cycle with hostile inputs that must be ignored
  task automatic redir(string n, logic [31:0] pc);
    clr();
    bus.inst_valid = 1'b1;
    bus.exp_vector = 2'b10;
    bus.csr_rw     = 1'b1;
    bus.csr_funct3 = 3'b001;
    bus.csr_addr   = 12'h341;
    bus.rs1_data   = 32'hFFFF_FFFF;
    ev(n, 6'b111100, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    rd(12'h300, 32'h0, "rst_mstatus");
    rd(12'h305, RST_VEC, "rst_mtvec");
    rd(12'h342, 32'h0, "rst_mcause");
`ifndef MCYCLE_EN
    rd(12'hB00, 32'h0, "mcycle_absent");
`endif

    csr(3'b001, 12'h305, 0, 32'h0000_0103, RST_VEC, "mtvec_wr");
    rd(12'h305, 32'h0000_0100, "mtvec_rd");

    clr();
    bus.inst_valid = 1'b1;
    bus.exp_vector = 2'b10;
    bus.inst_word  = 32'hFFFF_FFFF;
    bus.epc_cur    = 32'h40;
    ev("ill_entry", 6'b011111, 32'h0);
    redir("ill_redir", 32'h100);
    rd(12'h341, 32'h40, "ill_mepc");
    rd(12'h342, 32'd2, "ill_mcause");
    rd(12'h343, 32'hFFFF_FFFF, "ill_mtval");
    rd(12'h300, 32'h0, "ill_mstatus");

    csr(3'b110, 12'h300, 1, 32'h8, 32'h0, "mie_set");
    rd(12'h300, 32'h8, "mstatus_mie");
    clr();
    bus.inst_valid = 1'b1;
    bus.exp_vector = 2'b01;
    bus.epc_cur    = 32'h80;
    bus.inst_word  = 32'h0000_0073;
    ev("ecall_entry", 6'b011111, 32'h0);
    redir("ecall_redir", 32'h100);
    rd(12'h342, 32'd11, "ecall_mcause");
    rd(12'h300, 32'h80, "ecall_mstatus");
    rd(12'h343, 32'h0, "ecall_mtval");
    clr();
    bus.inst_valid = 1'b1;
    bus.mret       = 1'b1;
    ev("mret_entry", 6'b011110, 32'h0);
    redir("mret_redir", 32'h80);
    rd(12'h300, 32'h88, "mret_mstatus");

    csr(3'b111, 12'h300, 1, 32'h8, 32'h88, "mie_clr");
    clr();
    bus.inst_valid = 1'b1;
    bus.interrupt  = 1'b1;
    bus.csr_addr   = 12'h344;
    push("irq_masked", 1, 32'h800, 1, 6'b000000, 32'h0);
    cyc();
    csr(3'b010, 12'h304, 0, 32'h800, 32'h0, "meie_set");
    csr(3'b110, 12'h300, 1, 32'h8, 32'h80, "mie_set2");
    clr();
    bus.interrupt = 1'b1;
    bus.epc_next  = 32'h104;
    ev("irq_wait", 6'b000000, 32'h0);
    clr();
    bus.inst_valid = 1'b1;
    bus.interrupt  = 1'b1;
    bus.mret       = 1'b1;
    bus.epc_cur    = 32'h100;
    bus.epc_next   = 32'h104;
    ev("irq_entry", 6'b011110, 32'h0);
    redir("irq_redir", 32'h100);
    rd(12'h342, 32'h8000_000B, "irq_mcause");
    rd(12'h341, 32'h104, "irq_mepc");
    rd(12'h300, 32'h80, "irq_mstatus");
    rd(12'h343, 32'h0, "irq_mtval");

    csr(3'b010, 12'h341, 0, 32'h0, 32'h104, "set_zero");
    rd(12'h341, 32'h104, "set_zero_rd");
    csr(3'b001, 12'h300, 0, 32'hFFFF_FFFF, 32'h80, "mst_wr");
    rd(12'h300, 32'h88, "mst_mask");
    rd(12'h304, 32'h800, "mie_rd");
    csr(3'b001, 12'h123, 0, 32'hFFFF_FFFF, 32'h0, "bad_wr");
    rd(12'h123, 32'h0, "bad_rd");

    clr();
    bus.inst_valid = 1'b1;
    bus.exp_vector = 2'b11;
    bus.csr_rw     = 1'b1;
    bus.csr_funct3 = 3'b001;
    bus.csr_addr   = 12'h341;
    bus.rs1_data   = 32'hDEAD_BEE0;
    bus.epc_cur    = 32'h200;
    bus.inst_word  = 32'h1234_5678;
    ev("prio_entry", 6'b011111, 32'h0);
    redir("prio_redir", 32'h100);
    rd(12'h341, 32'h200, "prio_mepc");
    rd(12'h342, 32'd2, "prio_mcause");
    rd(12'h343, 32'h1234_5678, "prio_mtval");

    clr();
    bus.inst_valid = 1'b1;
    bus.exp_vector = 2'b01;
    bus.epc_cur    = 32'h300;
    ev("rst_trap", 6'b011111, 32'h0);
    clr();
    rst = 1'b1;
    ev("rst_in_redir", 6'b111100, 32'h100);
    rst = 1'b0;
    rd(12'h305, RST_VEC, "post_rst_mtvec");
    rd(12'h341, 32'h0, "post_rst_mepc");
    rd(12'h342, 32'h0, "post_rst_mcause");
    rd(12'h300, 32'h0, "post_rst_mstatus");
    rd(12'h304, 32'h0, "post_rst_mie");

    clr();
    repeat (2) cyc();
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain left %0d exp 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Consumer side of the decoder's exception/CSR outputs.
- Sits at the MEM/WB boundary of the 5-stage pipeline.
- Holds the machine-mode CSRs and executes CSR read/write for CSRRW/S/C[I].
- Takes traps on illegal instruction, ECALL or external interrupt, executes MRET, and produces the pipeline flush and PC-redirect controls.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- XLEN, 32, data width (only 32 supported).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  WB-stage instruction is real (not bubble/flushed)
- exp_vector  in  2  {illegal_inst, ecall} from the decoder
- mret  in  1  WB instruction is MRET
- interrupt  in  1  external interrupt request, level
- csr_rw  in  1  WB instruction is a CSR op
- csr_w_imm_mux  in  1  1: operand is zimm; 0: rs1_data
- csr_funct3  in  3  low 2 bits select op: 01 write, 10 set, 11 clear
- csr_addr  in  12  CSR address
- rs1_data  in  32  register operand
- zimm  in  5  immediate operand, zero-extended
- epc_cur  in  32  PC of the WB instruction
- epc_next  in  32  PC of the next valid instruction (interrupt return address)
- inst_word  in  32  raw WB instruction, used for mtval
- csr_rdata  out  32  old CSR value, combinational
- redirect_mux  out  1  1: fetch from redirect_pc
- redirect_pc  out  32  trap/return target
- reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush  out  1 each  pipeline flushes
- RegWrite_cancel  out  1  suppress WB register write of the trapping instruction

Behaviour:
- Reset, synchronous, active-high:
  - mstatus=0, mie=0, mepc=0, mcause=0, mtval=0, mtvec=MTVEC_RST, state=IDLE.
  - All outputs 0 except csr_rdata, which follows the combinational read.
- Implemented CSRs:
  - mstatus 0x300: only MIE bit 3 and MPIE bit 7 are writable; other bits read 0.
  - mie 0x304: bit 11 only.
  - mtvec 0x305: bits [1:0] forced to 0.
  - mepc 0x341, mcause 0x342, mtval 0x343: fully writable.
  - mip 0x344: read-only, bit 11 = interrupt.
  - Any other address reads 0; writes are ignored.
- Event evaluation in IDLE with inst_valid=1, in priority order:
  1. illegal: mcause=2, mtval=inst_word, mepc=epc_cur.
  2. ecall: mcause=11, mtval=0, mepc=epc_cur.
  3. interrupt taken when mstatus.MIE & mie[11]: mcause=32'h8000_000B, mtval=0, mepc=epc_next. The WB instruction completes normally.
  4. mret.
  5. csr_rw.
- Trap entry cycle (IDLE):
  - Assert all four flushes.
  - RegWrite_cancel=1 for illegal/ecall only.
  - At the edge: MPIE<=MIE, MIE<=0, write mepc/mcause/mtval; state->REDIR, redirect target latched to mtvec.
- MRET cycle (IDLE):
  - Assert all flushes.
  - At the edge: MIE<=MPIE, MPIE<=1; target latched to mepc; state->REDIR.
- REDIR (exactly 1 cycle):
  - redirect_mux=1, redirect_pc=latched target.
  - FD/DE/EM flushes stay asserted; all inputs are ignored.
  - Next state is IDLE.
- CSR op (IDLE, no higher-priority event):
  - csr_rdata = old value; the WB register gets the old value.
  - New value at the clock edge: write = op; set = old | op; clear = old & ~op.
  - op is zext(zimm) if csr_w_imm_mux, else rs1_data.
  - Set/clear with op==0 performs no write.
- Simultaneous events:
  - A trap suppresses a CSR write and an MRET in the same cycle.
  - An MRET plus a pending interrupt takes the interrupt first.
- inst_valid=0 in IDLE: no state change, no outputs asserted. An interrupt waits for a valid instruction.
- Reset asserted in REDIR: returns to IDLE, redirect_mux=0 in the next cycle.
- Trap latency: redirect is issued exactly 1 cycle after the event cycle.

Optional Feature:
- Macro: MCYCLE_EN.
- Defined:
  - 64-bit mcycle counter, reset 0, increments every cycle (wraps 2^64-1 -> 0).
  - Readable at 0xB00 (low) and 0xB80 (high), writable via CSR ops.
  - A CSR write to a half replaces that half in that cycle; the increment is skipped that cycle.
- Undefined: those addresses read 0 and writes are ignored.

Decomposition:
- Shared package exc_pkg holds:
  - CSR address constants.
  - mcause codes: CAUSE_ILLEGAL=2, CAUSE_ECALL_M=11, CAUSE_MEXT_INT=32'h8000_000B.
  - mstatus bit indices.
  - State encoding: IDLE=0, REDIR=1.
- One natural sub-module: csr_regfile. It holds the CSR storage, read mux and write/set/clear logic. exception_unit keeps the FSM, priority logic and flush/redirect outputs.

Test Plan:
- Write then read: CSRRW 0x305, rs1_data=0x0000_0103 -> next read of mtvec = 0x0000_0100; csr_rdata during the write = MTVEC_RST.
- Illegal instruction: exp_vector=2'b10, inst_word=0xFFFF_FFFF, epc_cur=0x40 -> flushes=1 and RegWrite_cancel=1 that cycle; next cycle redirect_mux=1, redirect_pc=mtvec; mepc=0x40, mcause=2, mtval=0xFFFF_FFFF, MIE=0.
- ECALL then MRET with MIE=1: ecall at epc_cur=0x80 -> mcause=11, MPIE=1, MIE=0; later MRET -> redirect_pc=0x80, MIE=1, MPIE=1.
- Interrupt gating:
  - MIE=0, interrupt=1 -> no trap.
  - Set MIE=1 and mie[11]=1 with epc_next=0x104 -> mcause=0x8000_000B, mepc=0x104, RegWrite_cancel=0.
- Priority and reset: exp_vector=2'b11 with csr_rw=1 to 0x341 -> mcause=2 and mepc=epc_cur, not the CSR value. Assert rst during REDIR -> next cycle redirect_mux=0 and all CSRs at reset values.
